prog_clock_divider: RTL and testbench

- Runtime-programmable integer clock divider.
- Generalises the fixed div2/div4/div8 divider to any divisor from 2 to 2^WIDTH-1.
- Divisor changes are glitch-free, odd divisors are supported, and start/stop is clean.
- Produces a divided clock plus a one-cycle `tick` strobe for logic that stays on `clk`. Sits between the system clock and slow peripheral or timing logic.

---
 rtl/prog_clock_divider_if.sv | 23 ++
 rtl/prog_clock_divider.sv | 129 ++++++++++++
 tb/tb_prog_clock_divider.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_clock_divider_if.sv
// Bundle of control, status and divided-clock signals for prog_clock_divider.
// The master side drives run/load requests; the slave (the divider) returns status.
interface prog_clock_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_val;
  logic             clk_out;
  logic             tick;
  logic             upd_pend;
  logic [WIDTH-1:0] cur_div;

  modport master (
    output en, load, div_val,
    input  clk_out, tick, upd_pend, cur_div
  );

  modport slave (
    input  en, load, div_val,
    output clk_out, tick, upd_pend, cur_div
  );
endinterface

// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider with glitch-free divisor updates at period boundaries.
// Define PCD_ODD_DUTY50_EN to add a negedge flop that gives odd divisors an exact 50% duty.
module prog_clock_divider #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  prog_clock_divider_if.slave         bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             upd_pend_q, upd_pend_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;

  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH:0]   hi_thresh;
  logic [WIDTH-1:0] div_clamped;
  logic             at_bound;
  logic             start;

  // Extra MSB keeps cnt+1 and the threshold exact when D = 2^WIDTH-1.
  assign cnt_inc = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
`ifdef PCD_ODD_DUTY50_EN
  assign hi_thresh = {1'b0, act_div_q} >> 1;
`else
  assign hi_thresh = ({1'b0, act_div_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
`endif
  assign at_bound    = (cnt_q == act_div_q - WIDTH'(1));
  assign div_clamped = (bus.div_val < WIDTH'(2)) ? WIDTH'(2) : bus.div_val;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    pend_div_d = pend_div_q;
    upd_pend_d = upd_pend_q;
    pos_d      = 1'b0;
    tick_d     = 1'b0;
    start      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        start = bus.en;
      end
      StRun: begin
        if (at_bound) begin
          if (bus.en) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc[WIDTH-1:0];
          pos_d = (cnt_inc < hi_thresh);
        end
      end
      default: state_d = StIdle;
    endcase

    // Period start: the pending divisor from before this edge takes effect.
    if (start) begin
      state_d = StRun;
      cnt_d   = '0;
      pos_d   = 1'b1;
      tick_d  = 1'b1;
      if (upd_pend_q) begin
        act_div_d  = pend_div_q;
        upd_pend_d = 1'b0;
      end
    end

    // A load on a boundary edge only queues; it is applied at the following boundary.
    if (bus.load) begin
      pend_div_d = div_clamped;
      upd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      act_div_q  <= WIDTH'(DEFAULT_DIV);
      pend_div_q <= WIDTH'(DEFAULT_DIV);
      upd_pend_q <= 1'b0;
      pos_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      pend_div_q <= pend_div_d;
      upd_pend_q <= upd_pend_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
    end
  end

`ifdef PCD_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle extension only for odd divisors so even divisors keep their duty.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q & act_div_q[0];
    end
  end

  assign bus.clk_out = pos_q | neg_q;
`else
  assign bus.clk_out = pos_q;
`endif

  assign bus.tick     = tick_q;
  assign bus.upd_pend = upd_pend_q;
  assign bus.cur_div  = act_div_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed scenarios plus random traffic
// compared against a period/phase reference model.
module tb_prog_clock_divider;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned DEFAULT_DIV = 2;

  logic clk;
  logic rst_n;

  prog_clock_divider_if #(.WIDTH(WIDTH)) bus ();

  prog_clock_divider #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: is a period running, where in it are we, which divisor, what is queued.
  bit m_run;
  int m_phase;
  int m_d;
  int m_pend;
  bit m_pflag;

  function automatic void model_reset();
    m_run   = 1'b0;
    m_phase = 0;
    m_d     = DEFAULT_DIV;
    m_pend  = DEFAULT_DIV;
    m_pflag = 1'b0;
  endfunction

  function automatic void model_step(input bit e, input bit l, input int dv);
    bit period_done;
    period_done = !m_run || (m_phase == m_d - 1);
    if (period_done) begin
      m_phase = 0;
      m_run   = e;
      if (e && m_pflag) begin
        m_d     = m_pend;
        m_pflag = 1'b0;
      end
    end else begin
      m_phase++;
    end
    if (l) begin
      m_pend  = (dv < 2) ? 2 : dv;
      m_pflag = 1'b1;
    end
  endfunction

  function automatic bit exp_clk_pos();
    return m_run && (m_phase < (m_d + 1) / 2);
  endfunction

  function automatic bit exp_clk_neg();
`ifdef PCD_ODD_DUTY50_EN
    return m_run && (m_phase < m_d / 2);
`else
    return m_run && (m_phase < (m_d + 1) / 2);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".clk_out"},  32'(bus.clk_out),  32'(exp_clk_pos()));
    check({tag, ".tick"},     32'(bus.tick),     32'(m_run && m_phase == 0));
    check({tag, ".upd_pend"}, 32'(bus.upd_pend), 32'(m_pflag));
    check({tag, ".cur_div"},  32'(bus.cur_div),  32'(m_d));
  endtask

  // One clk period: drive, let the edge happen, check after posedge and after negedge.
  task automatic cycle(input bit e, input bit l, input int dv);
    bus.en      = e;
    bus.load    = l;
    bus.div_val = WIDTH'(dv);
    @(posedge clk);
    model_step(e, l, dv);
    #1;
    check_all("pos");
    @(negedge clk);
    #1;
    check("neg.clk_out", 32'(bus.clk_out), 32'(exp_clk_neg()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0);
  endtask

  task automatic bound_fail(input string tag);
    miscompares++;
    $error("FAIL %s: wait bound expired, observed phase %0d", tag, m_phase);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.div_val = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);

    // D=4 loaded in IDLE, applied on start.
    cycle(1'b0, 1'b1, 4);
    run(12);

    // D=5: odd divisor.
    cycle(1'b1, 1'b1, 5);
    run(16);

    // Back to D=4, then load 6 at phase 1.
    cycle(1'b1, 1'b1, 4);
    for (int i = 0; i < 64 && !(m_d == 4 && m_phase == 0); i++) run(1);
    if (!(m_d == 4 && m_phase == 0)) bound_fail("wait_d4");
    cycle(1'b1, 1'b1, 6);
    if (m_phase != 1) bound_fail("load_at_phase1");
    run(16);

    // Load on the boundary edge: one extra D=4 period expected.
    cycle(1'b1, 1'b1, 4);
    for (int i = 0; i < 64 && !(m_d == 4 && m_phase == 3); i++) run(1);
    if (!(m_d == 4 && m_phase == 3)) bound_fail("wait_bound");
    cycle(1'b1, 1'b1, 6);
    run(16);

    // Clamping of 0 and 1.
    cycle(1'b1, 1'b1, 0);
    run(10);
    cycle(1'b1, 1'b1, 1);
    run(6);
    cycle(1'b1, 1'b1, 3);
    run(6);
    cycle(1'b1, 1'b1, 1);
    run(8);

    // D=6, drop en at phase 1: period completes, then held low.
    cycle(1'b1, 1'b1, 6);
    for (int i = 0; i < 64 && !(m_d == 6 && m_phase == 1); i++) run(1);
    if (!(m_d == 6 && m_phase == 1)) bound_fail("wait_d6");
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 0);

    // Short en pulse in IDLE still yields a full period.
    cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 0);

    // Large divisor exercises the wide counter path.
    cycle(1'b1, 1'b1, 255);
    for (int i = 0; i < 520; i++) cycle(1'b1, (i == 300), 7);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit e, l;
      int dv;
      e  = ($urandom_range(0, 9) != 0);
      l  = ($urandom_range(0, 7) == 0);
      dv = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      cycle(e, l, dv);
    end

    // Asynchronous reset mid-period with a load pending.
    cycle(1'b1, 1'b1, 8);
    for (int i = 0; i < 64 && !(m_d == 8 && m_phase == 1); i++) run(1);
    if (!(m_d == 8 && m_phase == 1)) bound_fail("wait_d8");
    cycle(1'b1, 1'b1, 5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
